// File: rtl/word_memory_loader.sv
// Boot-time loader: packs a little-endian byte stream into DATA_W-bit words
// and writes them to consecutive memory indices starting at 0.
module word_memory_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done
);
  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [BC_W-1:0] LAST  = BC_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W:0]   cnt_n, target, tgt_n, clamp;
  logic [BC_W-1:0]   bcnt, bcnt_n;
  logic              take;

  // Oversized requests fill the whole memory once and never wrap the index.
  assign clamp = (num_words > DEPTH) ? DEPTH : num_words;
  assign take  = (state == LOAD) && byte_valid;

  assign byte_ready = (state == LOAD);
  assign mem_we     = (state == WRITE);
  assign busy       = (state == LOAD) || (state == WRITE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_addr   <= '0;
      word_count <= '0;
      target     <= '0;
      bcnt       <= '0;
    end else begin
      state      <= state_n;
      mem_addr   <= addr_n;
      word_count <= cnt_n;
      target     <= tgt_n;
      bcnt       <= bcnt_n;
    end
  end

  // Byte lane k takes the k-th accepted byte of a word; untouched lanes keep stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata <= '0;
    end else if (take) begin
      for (int k = 0; k < BYTES; k++)
        if (bcnt == BC_W'(k)) mem_wdata[8*k +: 8] <= byte_data;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
    cnt_n   = word_count;
    tgt_n   = target;
    bcnt_n  = bcnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          tgt_n   = clamp;
          cnt_n   = '0;
          addr_n  = '0;
          bcnt_n  = '0;
          state_n = (clamp == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (byte_valid) begin
          bcnt_n = bcnt + 1'b1;
          if (bcnt == LAST) state_n = WRITE;
        end
      end
      WRITE: begin
        bcnt_n = '0;
        cnt_n  = word_count + 1'b1;
        if (cnt_n == target) begin
          state_n = DONE;
        end else begin
          addr_n  = mem_addr + 1'b1;
          state_n = LOAD;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_word_memory_loader.sv
// Directed bench for word_memory_loader: logs every write pulse and checks
// addresses, data, write latency, clamp, reset abort and start handling.
module tb_word_memory_loader;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_words = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready, mem_we, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;

  logic [ADDR_W-1:0] la[$];
  logic [DATA_W-1:0] ld[$];
  int                lc[$];

  word_memory_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      la.push_back(mem_addr);
      ld.push_back(mem_wdata);
      lc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    la.delete();
    ld.delete();
    lc.delete();
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_words = (ADDR_W+1)'(n);
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("push_timeout", 1, 0);
    step();
    last_acc = cyc;
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk(tag, done, 1);
  endtask

  initial begin
    logic [7:0] b1[8];
    int sz;
    int addr_err;
    b1 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // reset state
    #12;
    chk("rst_outs", {byte_ready, mem_we, busy, done}, 4'b0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // two words at full rate
    clr_log();
    do_start(2);
    chk("t1_busy", busy, 1);
    foreach (b1[i]) push(b1[i]);
    wait_done("t1_done");
    chk("t1_nwr", la.size(), 2);
    if (la.size() == 2) begin
      chk("t1_a0", la[0], 0);
      chk("t1_d0", ld[0], 32'h12345678);
      chk("t1_a1", la[1], 1);
      chk("t1_d1", ld[1], 32'hDEADBEEF);
      chk("t1_lat", lc[1], last_acc);
    end
    chk("t1_count", word_count, 2);
    chk("t1_busy_end", busy, 0);
    chk("t1_addr_end", mem_addr, 1);

    // one word, byte_valid toggling with junk on idle cycles
    clr_log();
    do_start(1);
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b0;
      byte_data  = 8'hFF;
      step();
      push(8'(8'h11 * (i + 1)));
    end
    step();
    step();
    chk("t2_nwr", la.size(), 1);
    if (la.size() == 1) begin
      chk("t2_a0", la[0], 0);
      chk("t2_d0", ld[0], 32'h44332211);
      chk("t2_lat", lc[0], last_acc);
    end
    chk("t2_done", done, 1);
    chk("t2_count", word_count, 1);

    // zero-length load goes straight to DONE and never accepts bytes
    clr_log();
    byte_valid = 1'b1;
    do_start(0);
    chk("t3_done", done, 1);
    chk("t3_count", word_count, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ready", byte_ready, 0);
      step();
    end
    byte_valid = 1'b0;
    chk("t3_nwr", la.size(), 0);

    // clamp: 600 requested, 512 written
    clr_log();
    do_start(600);
    for (int i = 0; i < 2048; i++) push(8'(i));
    wait_done("t4_done");
    sz = la.size();
    chk("t4_nwr", sz, 512);
    addr_err = 0;
    for (int i = 0; i < sz; i++) if (la[i] != ADDR_W'(i)) addr_err++;
    chk("t4_addr_seq", addr_err, 0);
    if (sz > 0) begin
      chk("t4_last_addr", la[sz-1], 511);
      chk("t4_last_data", ld[sz-1], 32'hFFFEFDFC);
    end
    chk("t4_count", word_count, 512);
    byte_valid = 1'b1;
    step();
    chk("t4_no_extra", byte_ready, 0);
    byte_valid = 1'b0;

    // asynchronous reset in the middle of a word
    clr_log();
    do_start(5);
    for (int i = 0; i < 14; i++) push(8'(8'h30 + i));
    sz = la.size();
    chk("t5_pre_nwr", sz, 3);
    byte_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_outs", {byte_ready, mem_we, busy, done}, 4'b0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);
    chk("t5_count", word_count, 0);
    step();
    step();
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("t5_no_wr", la.size(), sz);
    clr_log();
    do_start(1);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    wait_done("t5_done");
    chk("t5_nwr", la.size(), 1);
    if (la.size() == 1) begin
      chk("t5_a0", la[0], 0);
      chk("t5_d0", ld[0], 32'hDDCCBBAA);
    end

    // start during LOAD is ignored, start in DONE restarts at 0
    clr_log();
    do_start(2);
    push(8'h01); push(8'h02);
    start = 1'b1;
    num_words = 10'd7;
    step();
    start = 1'b0;
    chk("t6_busy", busy, 1);
    push(8'h03); push(8'h04);
    push(8'h05); push(8'h06); push(8'h07); push(8'h08);
    wait_done("t6_done");
    chk("t6_count", word_count, 2);
    chk("t6_nwr", la.size(), 2);
    if (la.size() == 2) begin
      chk("t6_a0", la[0], 0);
      chk("t6_d0", ld[0], 32'h04030201);
      chk("t6_a1", la[1], 1);
      chk("t6_d1", ld[1], 32'h08070605);
    end
    clr_log();
    do_start(1);
    chk("t6_rs_busy", busy, 1);
    chk("t6_rs_addr", mem_addr, 0);
    chk("t6_rs_count", word_count, 0);
    push(8'h9A); push(8'hBC); push(8'hDE); push(8'hF0);
    wait_done("t6_rs_done");
    chk("t6_rs_nwr", la.size(), 1);
    if (la.size() == 1) begin
      chk("t6_rs_a0", la[0], 0);
      chk("t6_rs_d0", ld[0], 32'hF0DEBC9A);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
